// File: rtl/alu_md_if.sv
// Request/response bundle between the EX-stage sequencer and alu_md_unit.
interface alu_md_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [4:0]       alu_op;
  logic             sign;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, flush, alu_op, sign, in1, in2,
    input  in_ready, out_valid, result, zero, ovf, hi, lo
  );

  modport slave (
    input  in_valid, flush, alu_op, sign, in1, in2,
    output in_ready, out_valid, result, zero, ovf, hi, lo
  );
endinterface

// File: rtl/alu_md_unit.sv
// Registered integer ALU with iterative shift-add multiply, restoring divide and HI/LO registers.
// Single-cycle ops complete in one edge; MULT/DIV take WIDTH+1 edges.
module alu_md_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   reset,
  alu_md_if.slave bus
);
  localparam int unsigned Msb  = WIDTH - 1;
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [4:0] OpAdd  = 5'd0,  OpSub  = 5'd1,  OpAnd  = 5'd2,  OpOr   = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4,  OpNor  = 5'd5,  OpSll  = 5'd6,  OpSrl  = 5'd7;
  localparam logic [4:0] OpSra  = 5'd8,  OpSlt  = 5'd9,  OpNeq  = 5'd10, OpLui  = 5'd11;
  localparam logic [4:0] OpMult = 5'd12, OpDiv  = 5'd13, OpMfhi = 5'd14, OpMflo = 5'd15;
  localparam logic [4:0] OpMthi = 5'd16, OpMtlo = 5'd17;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, oval_q, oval_d;
  // ph/pl: running {high,low} product, or {remainder,dividend/quotient} when dividing
  logic [WIDTH-1:0]  ph_q, ph_d, pl_q, pl_d, a_q, a_d, x_q, x_d;
  logic              qn_q, qn_d, rn_q, rn_d, dz_q, dz_d, isdiv_q, isdiv_d;

  logic [WIDTH-1:0]  in1, in2, sum, diff, sc_res, a_mag, b_mag;
  logic [SHW-1:0]    shamt;
  logic              sc_ovf, accept, a_neg, b_neg, slt_bit;
  logic [WIDTH:0]    mul_sum, div_rs, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign in1   = bus.in1;
  assign in2   = bus.in2;
  assign shamt = in2[SHW-1:0];
  assign sum   = in1 + in2;
  assign diff  = in1 - in2;
  assign a_neg = bus.sign & in1[Msb];
  assign b_neg = bus.sign & in2[Msb];
  assign a_mag = a_neg ? -in1 : in1;
  assign b_mag = b_neg ? -in2 : in2;
  assign slt_bit = bus.sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

  assign bus.in_ready  = (state_q == StIdle) & ~reset;
  assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;
  assign bus.out_valid = oval_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (bus.alu_op)
      OpAdd: begin
        sc_res = sum;
        sc_ovf = bus.sign & (in1[Msb] == in2[Msb]) & (sum[Msb] != in1[Msb]);
      end
      OpSub: begin
        sc_res = diff;
        sc_ovf = bus.sign & (in1[Msb] != in2[Msb]) & (diff[Msb] != in1[Msb]);
      end
      OpAnd:  sc_res = in1 & in2;
      OpOr:   sc_res = in1 | in2;
      OpXor:  sc_res = in1 ^ in2;
      OpNor:  sc_res = ~(in1 | in2);
      OpSll:  sc_res = in1 << shamt;
      OpSrl:  sc_res = in1 >> shamt;
      OpSra:  sc_res = $unsigned($signed(in1) >>> shamt);
      OpSlt:  sc_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OpNeq:  sc_res = {{(WIDTH-1){1'b0}}, (in1 != in2)};
      OpLui:  sc_res = in2 << (WIDTH / 2);
      OpMfhi: sc_res = hi_q;
      OpMflo: sc_res = lo_q;
      OpMthi, OpMtlo: sc_res = in1;
      default: sc_res = '0;
    endcase
  end

  assign mul_sum  = {1'b0, ph_q} + (pl_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign div_rs   = {ph_q, pl_q[Msb]};
  assign div_diff = div_rs - {1'b0, a_q};
  assign prod     = {ph_q, pl_q};
  assign prod_fix = qn_q ? -prod : prod;

  always_comb begin
    state_d = state_q; cnt_d = cnt_q;
    hi_d = hi_q; lo_d = lo_q; res_d = res_q;
    zero_d = zero_q; ovf_d = ovf_q; oval_d = 1'b0;
    ph_d = ph_q; pl_d = pl_q; a_d = a_q; x_d = x_q;
    qn_d = qn_q; rn_d = rn_q; dz_d = dz_q; isdiv_d = isdiv_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.alu_op == OpMult || bus.alu_op == OpDiv) begin
            isdiv_d = (bus.alu_op == OpDiv);
            state_d = isdiv_d ? StDiv : StMul;
            cnt_d   = '0;
            ph_d    = '0;
            // MUL: a=multiplicand, pl=multiplier; DIV: a=divisor, pl=dividend
            a_d     = isdiv_d ? b_mag : a_mag;
            pl_d    = isdiv_d ? a_mag : b_mag;
            x_d     = in1;
            qn_d    = a_neg ^ b_neg;
            rn_d    = a_neg;
            dz_d    = (in2 == '0);
          end else begin
            res_d  = sc_res;
            zero_d = (sc_res == '0);
            ovf_d  = sc_ovf;
            oval_d = 1'b1;
            if (bus.alu_op == OpMthi) hi_d = in1;
            if (bus.alu_op == OpMtlo) lo_d = in1;
          end
        end
      end
      StMul, StDiv: begin
        if (bus.flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          if (state_q == StMul) begin
            ph_d = mul_sum[WIDTH:1];
            pl_d = {mul_sum[0], pl_q[Msb:1]};
          end else if (div_rs >= {1'b0, a_q}) begin
            ph_d = div_diff[Msb:0];
            pl_d = {pl_q[Msb-1:0], 1'b1};
          end else begin
            ph_d = div_rs[Msb:0];
            pl_d = {pl_q[Msb-1:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StFix;
            cnt_d   = '0;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!bus.flush) begin
          if (!isdiv_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[Msb:0];
          end else if (dz_q) begin
            hi_d = x_q;
            lo_d = '1;
          end else begin
            hi_d = rn_q ? -ph_q : ph_q;
            lo_d = qn_q ? -pl_q : pl_q;
          end
          res_d  = lo_d;
          zero_d = (lo_d == '0);
          ovf_d  = 1'b0;
          oval_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle; cnt_q <= '0;
      hi_q <= '0; lo_q <= '0; res_q <= '0;
      zero_q <= 1'b1; ovf_q <= 1'b0; oval_q <= 1'b0;
      ph_q <= '0; pl_q <= '0; a_q <= '0; x_q <= '0;
      qn_q <= 1'b0; rn_q <= 1'b0; dz_q <= 1'b0; isdiv_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;
      hi_q <= hi_d; lo_q <= lo_d; res_q <= res_d;
      zero_q <= zero_d; ovf_q <= ovf_d; oval_q <= oval_d;
      ph_q <= ph_d; pl_q <= pl_d; a_q <= a_d; x_q <= x_d;
      qn_q <= qn_d; rn_q <= rn_d; dz_q <= dz_d; isdiv_q <= isdiv_d;
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// Scoreboard bench for alu_md_unit: directed ops push expected responses, a negedge monitor
// pops and compares on every out_valid.
module tb_alu_md_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_md_if #(.WIDTH(32)) bus ();

  alu_md_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0 result=%h", bus.result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_res"},  {32'd0, bus.result}, {32'd0, e.res});
        chk({e.name, "_zero"}, {63'd0, bus.zero},   {63'd0, e.z});
        chk({e.name, "_ovf"},  {63'd0, bus.ovf},    {63'd0, e.o});
        chk({e.name, "_hilo"}, {bus.hi, bus.lo},    {e.hi, e.lo});
      end
    end
  end

  task automatic push(input string name, input logic [31:0] r, input logic o,
                      input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.name = name; e.res = r; e.z = (r == 32'd0); e.o = o; e.hi = h; e.lo = l;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] op, input logic s, input logic [31:0] a,
                       input logic [31:0] b);
    bus.alu_op = op; bus.sign = s; bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sc(input string name, input logic [4:0] op, input logic s,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                    input logic o, input logic [31:0] h, input logic [31:0] l);
    push(name, r, o, h, l);
    drive(op, s, a, b);
  endtask

  task automatic md(input string name, input logic [4:0] op, input logic s,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] h,
                    input logic [31:0] l);
    int n;
    chk({name, "_ready_before"}, {63'd0, bus.in_ready}, 64'd1);
    push(name, l, 1'b0, h, l);
    drive(op, s, a, b);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'd33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.alu_op = 5'd0; bus.sign = 1'b0;
    bus.in1 = '0; bus.in2 = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", {32'd0, bus.result}, 64'd0);
    chk("rst_flags", {61'd0, bus.zero, bus.ovf, bus.out_valid}, 64'b100);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

    // Single-cycle ops, issued back to back
    sc("add_s",  5'd0,  1, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0, 0);
    sc("add_u",  5'd0,  0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 0, 0);
    sc("sub_s",  5'd1,  1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1, 0, 0);
    sc("sra",    5'd8,  0, 32'h80000000, 32'h24, 32'hF8000000, 0, 0, 0);
    sc("lui",    5'd11, 0, 32'h0, 32'h1234, 32'h12340000, 0, 0, 0);
    sc("neq_eq", 5'd10, 0, 32'd5, 32'd5, 32'd0, 0, 0, 0);
    sc("neq_ne", 5'd10, 0, 32'd5, 32'd6, 32'd1, 0, 0, 0);
    sc("slt_s",  5'd9,  1, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0);
    sc("slt_u",  5'd9,  0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0, 0);
    sc("and",    5'd2,  0, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0);
    sc("or",     5'd3,  0, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0, 0);
    sc("xor",    5'd4,  0, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 0, 0);
    sc("nor",    5'd5,  0, 32'hF0F0, 32'h0F0F, 32'hFFFF0000, 0, 0, 0);
    sc("sll",    5'd6,  0, 32'd1, 32'd31, 32'h80000000, 0, 0, 0);
    sc("srl",    5'd7,  0, 32'h80000000, 32'h21, 32'h40000000, 0, 0, 0);
    sc("undef",  5'd20, 0, 32'h1234, 32'h5678, 32'd0, 0, 0, 0);
    sc("mthi",   5'd16, 0, 32'h11, 32'd0, 32'h11, 0, 32'h11, 0);
    sc("mtlo",   5'd17, 0, 32'h22, 32'd0, 32'h22, 0, 32'h11, 32'h22);
    sc("mfhi",   5'd14, 0, 32'd0, 32'd0, 32'h11, 0, 32'h11, 32'h22);
    sc("mflo",   5'd15, 0, 32'd0, 32'd0, 32'h22, 0, 32'h11, 32'h22);

    // Iterative ops
    md("mult_s",  5'd12, 1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md("mult_u",  5'd12, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    md("div_s",   5'd13, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md("div_z",   5'd13, 1, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
    md("div_min", 5'd13, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    md("div_u",   5'd13, 0, 32'd100, 32'd7, 32'd2, 32'd14);
    sc("mfhi_div", 5'd14, 0, 32'd0, 32'd0, 32'd2, 0, 32'd2, 32'd14);

    // Flush mid-divide
    sc("mthi_aa", 5'd16, 0, 32'hAA, 32'd0, 32'hAA, 0, 32'hAA, 32'd14);
    sc("mtlo_bb", 5'd17, 0, 32'hBB, 32'd0, 32'hBB, 0, 32'hAA, 32'hBB);
    drive(5'd13, 1'b0, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("busy_before_flush", {63'd0, bus.in_ready}, 64'd0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("ready_after_flush", {63'd0, bus.in_ready}, 64'd1);
    chk("hilo_after_flush", {bus.hi, bus.lo}, {32'hAA, 32'hBB});
    repeat (40) @(posedge clk);
    #1;
    chk("hilo_flush_settled", {bus.hi, bus.lo}, {32'hAA, 32'hBB});
    sc("mfhi_flush", 5'd14, 0, 32'd0, 32'd0, 32'hAA, 0, 32'hAA, 32'hBB);

    // Flush while idle blocks acceptance
    bus.flush = 1'b1;
    drive(5'd0, 1'b0, 32'd4, 32'd4);
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_flush_result", {32'd0, bus.result}, {32'd0, 32'hAA});

    // Asynchronous reset mid-multiply
    drive(5'd12, 1'b0, 32'd5, 32'd6);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("midrst_result", {32'd0, bus.result}, 64'd0);
    chk("midrst_flags", {61'd0, bus.zero, bus.ovf, bus.out_valid}, 64'b100);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrst_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_ready_rel", {63'd0, bus.in_ready}, 64'd1);
    sc("add_after_rst", 5'd0, 0, 32'd1, 32'd2, 32'd3, 0, 0, 0);

    repeat (40) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU, for the multi-cycle/pipelined CPU.
- Executes all existing integer ops with a 1-cycle registered latency.
- Adds iterative MULT/DIV with HI/LO registers, an overflow flag, a valid/ready input handshake and a flush.
- Sits in the EX stage. The hazard unit stalls on in_ready low.

Parameters:
- WIDTH, 32, datapath width. Must be even and >= 8.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from in2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; an op is accepted on an edge where in_valid & in_ready
- flush  in  1  synchronous abort of any in-flight MULT/DIV
- alu_op  in  5  operation code (list below)
- sign  in  1  1 = signed interpretation for SLT, MULT, DIV, overflow
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- out_valid  out  1  one-cycle pulse: result, zero and ovf are valid
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- ovf  out  1  signed ADD/SUB overflow (sign=1 only), else 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 NEQ, 11 LUI
  - 12 MULT, 13 DIV, 14 MFHI, 15 MFLO, 16 MTHI, 17 MTLO
  - 18-31: out_valid pulses, result = 0, HI/LO untouched.
- Shifts: in1 shifted by in2[SHW-1:0]. SRA is arithmetic regardless of sign.
- SLT: result 1/0; comparison is signed when sign=1, unsigned otherwise.
- NEQ: result = (in1 != in2), i.e. 0 when equal. Branch uses zero.
- LUI: result = in2 << (WIDTH/2).
- Overflow: ovf = 1 only for ADD/SUB with sign=1 on two's-complement overflow. Result is still the wrapped sum/difference.
- Single-cycle ops (0-11, 14-17):
  - Accepted at edge E. result, zero, ovf and out_valid update at E; out_valid drops at E+1.
  - Back-to-back issue every cycle is allowed.
  - MFHI/MFLO return the HI/LO value before edge E.
  - MTHI/MTLO write in1 to HI/LO at E; result = in1.
- FSM states: IDLE, MUL, DIV, FIX. in_ready = (state == IDLE) & ~reset.
- MULT/DIV sequencing:
  - Accepted at E0: operands are latched, converted to magnitudes if sign=1, and the state goes to MUL or DIV with the iteration counter = 0.
  - One shift-add (MUL) or restoring subtract (DIV) step per cycle for WIDTH cycles, then FIX (sign correction).
  - HI, LO, result and out_valid update at edge E0+WIDTH+1, after which the state returns to IDLE. Latency is WIDTH+1 edges; in_ready stays low throughout.
- MULT: {HI,LO} = full 2*WIDTH-bit product, signed or unsigned per sign. result = LO.
- DIV:
  - LO = quotient, HI = remainder, result = LO.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = in1. No exception.
  - Signed MIN / -1: LO = MIN, HI = 0.
- Flush: flush=1 while state != IDLE aborts to IDLE at the next edge.
  - HI/LO are unchanged, no out_valid.
  - in_ready is 1 the cycle after the flush.
  - flush in IDLE suppresses acceptance that cycle.
- Reset (asynchronous, mid-operation included):
  - result, hi, lo = 0; zero = 1; ovf, out_valid = 0; state IDLE; counter 0.
  - in_ready rises the first cycle after reset deasserts.
- No output backpressure. The consumer must sample on out_valid.

Test Plan:
- WIDTH=32, ADD sign=1: in1=0x7FFFFFFF, in2=1 -> next edge result=0x80000000, ovf=1, zero=0. Repeat with sign=0 -> ovf=0.
- SRA in1=0x80000000, in2=0x24 (shift 4) -> result 0xF8000000. LUI in2=0x1234 -> 0x12340000. NEQ 5,5 -> result 0, zero=1.
- MULT sign=1, in1=-3, in2=7:
  - in_ready low for exactly 33 cycles; out_valid at E0+33.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Unsigned 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV sign=1:
  - -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Divide by zero, in1=9 -> LO=0xFFFFFFFF, HI=9.
  - 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Flush at cycle 10 of a DIV, with HI/LO preloaded via MTHI/MTLO to 0xAA/0xBB -> no out_valid, HI/LO remain 0xAA/0xBB, in_ready=1 next cycle, MFHI returns 0xAA.
- Assert reset mid-MULT (cycle 5) -> all outputs at reset values immediately. After release, a single-cycle ADD 1+2 accepted next cycle -> result 3.
